// File: rtl/bbox_issue_arb_if.sv
// Bundle of request, datapath and response signals between the personality queues,
// the issue arbiter and the shared bbox_wrap datapath.
interface bbox_issue_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ*12-1:0]         req_arc0;
    logic [NREQ*64-1:0]         req_scalar;
    logic [NREQ*64-1:0]         req_va;
    logic [NREQ*64-1:0]         req_vb;

    logic [11:0]                dp_arc0;
    logic [63:0]                dp_scalar;
    logic [63:0]                dp_va;
    logic [63:0]                dp_vb;
    logic [63:0]                dp_vt;
    logic                       dp_vm;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [$clog2(NREQ)-1:0]    rsp_tag;
    logic [63:0]                rsp_vt;
    logic                       rsp_vm;
    logic                       idle;

    modport slave (
        input  req_valid, req_arc0, req_scalar, req_va, req_vb,
        input  dp_vt, dp_vm, rsp_ready,
        output req_ready, dp_arc0, dp_scalar, dp_va, dp_vb,
        output rsp_valid, rsp_tag, rsp_vt, rsp_vm, idle
    );

    modport master (
        output req_valid, req_arc0, req_scalar, req_va, req_vb,
        output dp_vt, dp_vm, rsp_ready,
        input  req_ready, dp_arc0, dp_scalar, dp_va, dp_vb,
        input  rsp_valid, rsp_tag, rsp_vt, rsp_vm, idle
    );
endinterface

// File: rtl/bbox_issue_arb.sv
// Round-robin issue controller for one shared bbox_wrap datapath: issues one instruction
// per clock, tracks it through the fixed-latency pipe and returns results in order.
module bbox_issue_arb #(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 8,
    parameter int CRED     = 8
) (
    input  logic             intfClk1x,
    input  logic             reset_n,
    bbox_issue_arb_if.slave  bus
);
    localparam int TAGW = $clog2(NREQ);
    localparam int CNTW = $clog2(CRED + 1);
    localparam int AW   = $clog2(CRED);

    logic [TAGW-1:0]  r_rrPtr;
    logic [CNTW-1:0]  r_cnt;
    logic [PIPE_LAT:0] r_vp;
    logic [TAGW-1:0]  r_tp [PIPE_LAT+1];

    logic [11:0]      r_dpArc0;
    logic [63:0]      r_dpScalar;
    logic [63:0]      r_dpVa;
    logic [63:0]      r_dpVb;

    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic [TAGW-1:0]  r_fifoTag [CRED];
    logic [63:0]      r_fifoVt  [CRED];
    logic [CRED-1:0]  r_fifoVm;

    int               w_scan;
    logic [TAGW-1:0]  w_scanIdx;
    logic             w_found;
    logic [TAGW-1:0]  w_grantIdx;
    logic [NREQ-1:0]  w_grant;
    logic             w_grantAny;
    logic             w_issueOk;
    logic             w_rspValid;
    logic             w_pop;
    logic             w_push;

    logic [11:0]      w_selArc0;
    logic [63:0]      w_selScalar;
    logic [63:0]      w_selVa;
    logic [63:0]      w_selVb;

    assign w_issueOk  = (r_cnt < CNTW'(CRED));
    assign w_rspValid = (r_wrPtr != r_rdPtr);
    assign w_pop      = w_rspValid & bus.rsp_ready;
    assign w_push     = r_vp[PIPE_LAT];
    assign w_grantAny = |w_grant;

    // First valid requester at or after the round-robin pointer, wrapping around.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        w_scan     = 0;
        w_scanIdx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan    = (int'(r_rrPtr) + k) % NREQ;
            w_scanIdx = TAGW'(w_scan);
            if (!w_found && bus.req_valid[w_scanIdx]) begin
                w_found    = 1'b1;
                w_grantIdx = w_scanIdx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (reset_n && w_found && w_issueOk) begin
            w_grant[w_grantIdx] = 1'b1;
        end
    end

    always_comb begin
        w_selArc0   = '0;
        w_selScalar = '0;
        w_selVa     = '0;
        w_selVb     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grantIdx == TAGW'(k)) begin
                w_selArc0   = bus.req_arc0[12*k +: 12];
                w_selScalar = bus.req_scalar[64*k +: 64];
                w_selVa     = bus.req_va[64*k +: 64];
                w_selVb     = bus.req_vb[64*k +: 64];
            end
        end
    end

    // Datapath operands: granted fields, or an all-zero bubble when nothing issues.
    always_ff @(posedge intfClk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_dpArc0   <= '0;
            r_dpScalar <= '0;
            r_dpVa     <= '0;
            r_dpVb     <= '0;
        end else if (w_grantAny) begin
            r_dpArc0   <= w_selArc0;
            r_dpScalar <= w_selScalar;
            r_dpVa     <= w_selVa;
            r_dpVb     <= w_selVb;
        end else begin
            r_dpArc0   <= '0;
            r_dpScalar <= '0;
            r_dpVa     <= '0;
            r_dpVb     <= '0;
        end
    end

    always_ff @(posedge intfClk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_rrPtr <= '0;
        end else if (w_grantAny) begin
            r_rrPtr <= (w_grantIdx == TAGW'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;
        end
    end

    // Valid/tag shadow of the datapath pipe; bubbles carry vp=0 and are never captured.
    always_ff @(posedge intfClk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_vp <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                r_tp[k] <= '0;
            end
        end else begin
            r_vp    <= {r_vp[PIPE_LAT-1:0], w_grantAny};
            r_tp[0] <= w_grantAny ? w_grantIdx : '0;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                r_tp[k] <= r_tp[k-1];
            end
        end
    end

    always_ff @(posedge intfClk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_grantAny, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge intfClk1x or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible between the pointers.
    always_ff @(posedge intfClk1x) begin
        if (w_push) begin
            r_fifoTag[r_wrPtr[AW-1:0]] <= r_tp[PIPE_LAT];
            r_fifoVt[r_wrPtr[AW-1:0]]  <= bus.dp_vt;
            r_fifoVm[r_wrPtr[AW-1:0]]  <= bus.dp_vm;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.dp_arc0   = r_dpArc0;
    assign bus.dp_scalar = r_dpScalar;
    assign bus.dp_va     = r_dpVa;
    assign bus.dp_vb     = r_dpVb;

    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_tag   = w_rspValid ? r_fifoTag[r_rdPtr[AW-1:0]] : '0;
    assign bus.rsp_vt    = w_rspValid ? r_fifoVt[r_rdPtr[AW-1:0]] : '0;
    assign bus.rsp_vm    = w_rspValid ? r_fifoVm[r_rdPtr[AW-1:0]] : 1'b0;
    assign bus.idle      = (r_cnt == '0);
endmodule
